// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: walks vector memory from address 0, tracks the pen and hands
// segments to the line drawer over a level-held go/busy handshake, restarting at a fixed frame rate.
module vector_list_sequencer #(
  parameter int unsigned ADDRESSWIDTH = 8,
  parameter int unsigned DATAWIDTH    = 18,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned FRAME_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [ADDRESSWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic                    go,
  input  logic                    draw_busy,
  output logic [OUT_WIDTH-1:0]    o_start_x,
  output logic [OUT_WIDTH-1:0]    o_start_y,
  output logic [OUT_WIDTH-1:0]    o_end_x,
  output logic [OUT_WIDTH-1:0]    o_end_y,
  output logic                    frame_done,
  output logic                    frame_overrun,
  output logic                    list_overflow
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ADDRESSWIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_DONE,
    S_WAIT
  } state_t;

  state_t                state;
  logic                  run_req;
  logic [CNT_W-1:0]      frame_cnt;
  logic [OUT_WIDTH-1:0]  pen_x;
  logic [OUT_WIDTH-1:0]  pen_y;

  logic                  entry_pos;
  logic                  entry_line;
  logic [OUT_WIDTH-1:0]  entry_x;
  logic [OUT_WIDTH-1:0]  entry_y;
  logic                  cnt_sat;
  logic                  step_done;
  logic                  at_last;
  logic                  pass_end;

  assign entry_pos  = data_in[0];
  assign entry_line = data_in[1];
  assign entry_x    = data_in[2 +: OUT_WIDTH];
  assign entry_y    = data_in[2+OUT_WIDTH +: OUT_WIDTH];

  assign cnt_sat = (frame_cnt == CNT_MAX);
  assign at_last = (addr == ADDR_LAST);

  // An entry completes on a decoded MOVE, or when the drawer drops busy after a segment.
  assign step_done = ((state == S_DECODE) && entry_pos && !entry_line) ||
                     ((state == S_DONE) && !draw_busy);
  assign pass_end  = ((state == S_DECODE) && !entry_pos && !entry_line) ||
                     (step_done && at_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      run_req       <= 1'b0;
      frame_cnt     <= '0;
      addr          <= '0;
      pen_x         <= '0;
      pen_y         <= '0;
      go            <= 1'b0;
      o_start_x     <= '0;
      o_start_y     <= '0;
      o_end_x       <= '0;
      o_end_y       <= '0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      list_overflow <= 1'b0;
    end else begin
      frame_done    <= pass_end;
      frame_overrun <= pass_end && cnt_sat;
      list_overflow <= step_done && at_last;
      run_req       <= (state == S_IDLE) && enable;

      if (!cnt_sat) frame_cnt <= frame_cnt + CNT_W'(1);

      if (step_done) begin
        addr  <= addr + ADDRESSWIDTH'(1);
        pen_x <= (state == S_DONE) ? o_end_x : entry_x;
        pen_y <= (state == S_DONE) ? o_end_y : entry_y;
      end

      case (state)
        S_IDLE: begin
          addr  <= '0;
          pen_x <= '0;
          pen_y <= '0;
          if (run_req) begin
            state     <= S_FETCH;
            frame_cnt <= '0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          // line=1 is DRAW or POINT; POINT (pos=1) starts at its own target.
          if (entry_line) begin
            o_start_x <= entry_pos ? entry_x : pen_x;
            o_start_y <= entry_pos ? entry_y : pen_y;
            o_end_x   <= entry_x;
            o_end_y   <= entry_y;
            go        <= !draw_busy;
            state     <= S_REQ;
          end else if (entry_pos) begin
            state <= S_FETCH;
          end
        end
        S_REQ: begin
          if (go && draw_busy) begin
            go    <= 1'b0;
            state <= S_DONE;
          end else if (!draw_busy) begin
            go <= 1'b1;
          end
        end
        S_DONE: begin
          if (!draw_busy) state <= S_FETCH;
        end
        S_WAIT: begin
          addr  <= '0;
          pen_x <= '0;
          pen_y <= '0;
          if (cnt_sat) begin
            if (enable) begin
              state     <= S_FETCH;
              frame_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (pass_end) begin
        state <= S_WAIT;
        addr  <= '0;
        pen_x <= '0;
        pen_y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench for vector_list_sequencer: a list-walking reference model predicts segments
// and frame events; a negedge monitor compares them as the DUT presents go and frame_done.
module tb_vector_list_sequencer;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 18;
  localparam int unsigned OW = 8;
  localparam int unsigned FC = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          go;
  logic          draw_busy;
  logic [OW-1:0] o_start_x, o_start_y, o_end_x, o_end_y;
  logic          frame_done, frame_overrun, list_overflow;

  vector_list_sequencer #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .OUT_WIDTH(OW), .FRAME_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr), .data_in(data_in),
    .go(go), .draw_busy(draw_busy),
    .o_start_x(o_start_x), .o_start_y(o_start_y), .o_end_x(o_end_x), .o_end_y(o_end_y),
    .frame_done(frame_done), .frame_overrun(frame_overrun), .list_overflow(list_overflow)
  );

  always #5 clk = ~clk;

  // Synchronous display-list memory: data valid one cycle after addr.
  logic [DW-1:0] mem [8];
  always @(posedge clk) data_in <= mem[addr];

  typedef struct { int sx; int sy; int ex; int ey; int glen; } seg_t;
  typedef struct { bit ovf; bit ovr; int gap; } frm_t;

  seg_t seg_q[$];
  frm_t frm_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dly   = 1;
  int   blen  = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, required none", name);
  endtask

  // kind: 0 END, 1 DRAW, 2 MOVE, 3 POINT, i.e. the two bits {pos,line}
  function automatic logic [DW-1:0] ent(input int kind, input int x, input int y);
    logic [1:0] k;
    k = 2'(kind);
    return {8'(y), 8'(x), k[0], k[1]};
  endfunction

  // Reference: walk the list like a display processor, costing each entry in clocks.
  task automatic model_run(input int reps);
    int px, py, total, x, y;
    bit ovf;
    logic [DW-1:0] e;
    seg_t s;
    frm_t f;
    for (int r = 0; r < reps; r++) begin
      px = 0; py = 0; total = 0; ovf = 1'b1;
      for (int a = 0; a < 8; a++) begin
        e = mem[a];
        x = int'(e[9:2]);
        y = int'(e[17:10]);
        if (e[1:0] == 2'b00) begin
          total += 2;
          ovf = 1'b0;
          break;
        end else if (e[1:0] == 2'b01) begin
          total += 2;
        end else begin
          s.sx = e[0] ? x : px;
          s.sy = e[0] ? y : py;
          s.ex = x;
          s.ey = y;
          s.glen = dly;
          seg_q.push_back(s);
          total += 2 + dly + blen;
        end
        px = x; py = y;
      end
      f.ovf = ovf;
      f.ovr = (total >= int'(FC));
      f.gap = (r == 0) ? 0 : ((total + 1 > int'(FC)) ? total + 1 : int'(FC));
      frm_q.push_back(f);
    end
  endtask

  // Line drawer model: busy rises dly cycles after go is seen, held for blen cycles.
  initial begin
    draw_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && go && !draw_busy) begin
        repeat (dly - 1) @(negedge clk);
        draw_busy = 1'b1;
        repeat (blen) @(negedge clk);
        draw_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a segment or ends a frame.
  initial begin
    int cyc, last_done, glen, exp_glen;
    bit go_p;
    logic [34:0] snap;
    seg_t s;
    frm_t f;
    cyc = 0; last_done = -1; glen = 0; exp_glen = 0; go_p = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        go_p = 1'b0;
        last_done = -1;
        continue;
      end
      if (go && !go_p) begin
        if (seg_q.size() == 0) begin
          fail("unexpected_go");
          exp_glen = 0;
        end else begin
          s = seg_q.pop_front();
          chk("seg_start_x", o_start_x, s.sx);
          chk("seg_start_y", o_start_y, s.sy);
          chk("seg_end_x", o_end_x, s.ex);
          chk("seg_end_y", o_end_y, s.ey);
          exp_glen = s.glen;
        end
        glen = 1;
        snap = {addr, o_start_x, o_start_y, o_end_x, o_end_y};
      end else if (go) begin
        glen++;
        chk("hold_stable", {addr, o_start_x, o_start_y, o_end_x, o_end_y}, snap);
      end else if (go_p) begin
        chk("go_len", glen, exp_glen);
      end
      go_p = go;
      if (frame_done) begin
        if (frm_q.size() == 0) begin
          fail("unexpected_frame_done");
        end else begin
          f = frm_q.pop_front();
          chk("list_overflow", list_overflow, f.ovf);
          chk("frame_overrun", frame_overrun, f.ovr);
          chk("frame_addr0", addr, 0);
          if (f.gap > 0 && last_done >= 0) chk("frame_gap", cyc - last_done, f.gap);
        end
        last_done = cyc;
      end else if (frame_overrun || list_overflow) begin
        fail("stray_pulse");
      end
    end
  end

  task automatic do_run(input int reps, input bit lat);
    int seen, t;
    seen = 0; t = 0;
    model_run(reps);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    if (reps == 1) enable = 1'b0;
    if (lat) begin
      @(negedge clk);
      @(negedge clk);
      chk("go_latency_early", go, 0);
      @(negedge clk);
      chk("go_latency", go, 1);
    end
    while (seen < reps && t < 3000) begin
      @(negedge clk);
      t++;
      if (frame_done) seen++;
    end
    enable = 1'b0;
    chk("frame_done_count", seen, reps);
    repeat (FC + 4) @(negedge clk);
    chk("idle_addr", addr, 0);
    chk("idle_go", go, 0);
    chk("segs_left", seg_q.size(), 0);
    chk("frames_left", frm_q.size(), 0);
    seg_q.delete();
    frm_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_outs"}, {o_start_x, o_start_y, o_end_x, o_end_y}, 0);
    chk({tag, "_pulses"}, {frame_done, frame_overrun, list_overflow}, 0);
  endtask

  initial begin
    int t, k;
    rst = 1'b1;
    enable = 1'b0;
    for (int a = 0; a < 8; a++) mem[a] = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // MOVE, DRAW, END running two passes: one segment per pass, FC-cycle period.
    mem[0] = ent(2, 10, 20); mem[1] = ent(1, 30, 40); mem[2] = ent(0, 0, 0);
    dly = 1; blen = 5;
    do_run(2, 1'b0);

    // Slow drawer holding go high; POINT after DRAW; enable dropped mid-pass.
    mem[0] = ent(1, 5, 5); mem[1] = ent(3, 255, 0); mem[2] = ent(1, 0, 0); mem[3] = ent(0, 0, 0);
    dly = 8; blen = 2;
    do_run(1, 1'b1);

    // Eight DRAWs and no END marker: wraps with list_overflow.
    for (int a = 0; a < 8; a++) mem[a] = ent(1, a * 30, 255 - a * 7);
    dly = 1; blen = 1;
    do_run(2, 1'b0);

    // Same list with a slow drawer overruns the frame.
    dly = 2; blen = 5;
    do_run(2, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 8; a++) begin
        k = int'($urandom_range(0, 11));
        mem[a] = ent((k == 0) ? 0 : 1 + (k % 3), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
      end
      dly  = int'($urandom_range(1, 4));
      blen = int'($urandom_range(1, 6));
      do_run(int'($urandom_range(1, 2)), 1'b0);
    end

    // Asynchronous reset while go is held in REQ.
    mem[0] = ent(1, 1, 2); mem[1] = ent(0, 0, 0);
    dly = 6; blen = 1;
    model_run(1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    t = 0;
    while (!go && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_req", go, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    seg_q.delete();
    frm_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
